// File: rtl/lut_neuron_loader.sv
// Runtime-loadable LUT neuron: serial table load into distributed RAM,
// then one-cycle registered lookups in the generated-neuron packing.
module lut_neuron_loader #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  output logic                cfg_done,
  output logic                loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  output logic [OUT_BITS-1:0] out_data
);

  localparam int DEPTH = 1 << IN_BITS;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SERVE
  } state_t;

  state_t state;
  state_t state_next;

  logic [IN_BITS-1:0] addr;
  logic [IN_BITS-1:0] addr_next;
  logic               loaded_next;
  logic               done_next;
  logic               wr_en;
  logic               last_wr;
  logic               rd_en;

  (* ram_style = "distributed" *)
  logic [OUT_BITS-1:0] mem [DEPTH];

  assign cfg_ready = (state == LOAD);
  assign in_ready  = (state == SERVE);
  assign wr_en     = cfg_valid && cfg_ready;
  assign last_wr   = wr_en && (addr == '1);
  assign rd_en     = in_valid && in_ready;

  always_comb begin
    state_next  = state;
    addr_next   = addr;
    loaded_next = loaded;
    done_next   = 1'b0;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_next = LOAD;
          addr_next  = '0;
        end
      end
      LOAD: begin
        // a restart wins over the final write's completion
        if (cfg_start) begin
          addr_next = '0;
        end else if (last_wr) begin
          state_next  = SERVE;
          addr_next   = addr + 1'b1;
          loaded_next = 1'b1;
          done_next   = 1'b1;
        end else if (wr_en) begin
          addr_next = addr + 1'b1;
        end
      end
      SERVE: begin
        if (cfg_start) begin
          state_next  = LOAD;
          addr_next   = '0;
          loaded_next = 1'b0;
        end
      end
      default: begin
        state_next  = IDLE;
        addr_next   = '0;
        loaded_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      loaded   <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      state    <= state_next;
      addr     <= addr_next;
      loaded   <= loaded_next;
      cfg_done <= done_next;
    end
  end

  // table contents survive reset; only the loaded flag is cleared
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= rd_en;
      if (rd_en) begin
        out_data <= mem[in_data];
      end
    end
  end

endmodule

// File: tb/tb_lut_neuron_loader.sv
// Scoreboard bench for lut_neuron_loader: directed loads and lookups,
// a negedge monitor pops expected lookup results.
module tb_lut_neuron_loader;

  logic       clk;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_data;
  logic       cfg_done;
  logic       loaded;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic [1:0] out_data;

  int checks;
  int failures;
  int done_cnt;
  int done_base;
  logic [1:0] sb[$];

  lut_neuron_loader #(.IN_BITS(8), .OUT_BITS(2)) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_data(cfg_data),
    .cfg_done(cfg_done),
    .loaded(loaded),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    logic [1:0] e;
    if (cfg_done) done_cnt++;
    if (out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out got=%0d required=no_output", out_data);
      end else begin
        e = sb.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL lookup_data got=%0d required=%0d", out_data, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic issue(input logic [7:0] a, input logic [1:0] e,
                       input bit accept);
    in_valid = 1'b1;
    in_data  = a;
    chk("in_ready", int'(in_ready), int'(accept));
    if (in_ready) sb.push_back(e);
    @(posedge clk); #1;
    chk("out_valid", int'(out_valid), int'(accept));
  endtask

  task automatic load(input int n, input logic [1:0] cval,
                      input bit use_k, input bit stall,
                      input bit do_start, input bit exp_done);
    int k;
    int guard;
    bit rdy;
    k = 0;
    guard = 0;
    if (do_start) begin
      cfg_start = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
    end
    while (k < n && guard < 4000) begin
      cfg_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_data  = use_k ? k[1:0] : cval;
      rdy = cfg_ready;
      @(posedge clk); #1;
      if (cfg_valid && rdy) k++;
      guard++;
    end
    cfg_valid = 1'b0;
    chk("load_accepts", k, n);
    if (exp_done) begin
      chk("cfg_done_pulse", int'(cfg_done), 1);
      chk("loaded_set", int'(loaded), 1);
      @(posedge clk); #1;
      chk("cfg_done_clear", int'(cfg_done), 0);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    done_cnt = 0;
    rst = 1'b0;
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = 2'b00;
    in_valid = 1'b0;
    in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // reset state, lookup refused
    in_valid = 1'b1;
    in_data  = 8'h05;
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 0);
    chk("rst_cfg_done", int'(cfg_done), 0);
    chk("rst_loaded", int'(loaded), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    issue(8'h05, 2'b00, 1'b0);
    in_valid = 1'b0;

    // full load, entry k = k[1:0]
    load(256, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(8'hC7, 2'b11, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // back-to-back lookups
    for (int i = 0; i < 4; i++) begin
      issue(8'(i), 2'(i), 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // stalled stream of 2'b10
    cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    chk("reload_clears_loaded", int'(loaded), 0);
    chk("reload_cfg_ready", int'(cfg_ready), 1);
    load(256, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(8'h00, 2'b10, 1'b1);
    issue(8'h80, 2'b10, 1'b1);
    issue(8'hFF, 2'b10, 1'b1);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // cfg_start alongside an accepted lookup: old data returned
    cfg_start = 1'b1;
    issue(8'h10, 2'b10, 1'b1);
    cfg_start = 1'b0;
    in_valid = 1'b0;
    chk("start_drops_in_ready", int'(in_ready), 0);

    // partial 2'b01 load, restart, full 2'b11 load
    done_base = done_cnt;
    load(100, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
    load(256, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("done_once", done_cnt - done_base, 1);

    // cfg_valid outside LOAD must not write
    cfg_valid = 1'b1;
    cfg_data  = 2'b00;
    chk("serve_cfg_ready", int'(cfg_ready), 0);
    repeat (3) @(posedge clk);
    #1 cfg_valid = 1'b0;
    for (int a = 0; a < 256; a++) begin
      issue(8'(a), 2'b11, 1'b1);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;

    // async reset mid-load
    load(50, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0);
    #3 rst = 1'b0;
    #1;
    chk("arst_cfg_ready", int'(cfg_ready), 0);
    chk("arst_in_ready", int'(in_ready), 0);
    chk("arst_loaded", int'(loaded), 0);
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_data", int'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    issue(8'h05, 2'b00, 1'b0);
    in_valid = 1'b0;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    chk("idle_loaded", int'(loaded), 0);
    load(256, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(8'hFF, 2'b11, 1'b1);
    issue(8'h42, 2'b10, 1'b1);
    in_valid = 1'b0;

    repeat (2) @(posedge clk);
    #1 chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lut_neuron_loader.md
Name: lut_neuron_loader

Overview:
- Runtime-programmable LUT neuron: the write-side counterpart of the fixed-ROM neuron tables generated for the hgcal autoencoder layers.
- Accepts a serial stream of truth-table entries, stores them in distributed RAM, then serves registered lookups with the same input/output packing as the generated neurons.
- Lets pipecleaner builds retarget neuron functions without re-synthesis.

Parameters:
- IN_BITS, 8, lookup address width (fan-in × input bit width); table depth is 2^IN_BITS.
- OUT_BITS, 2, output word width per entry.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_start  input  1  one-cycle pulse that begins a table load at address 0.
- cfg_valid  input  1  cfg_data is valid this cycle.
- cfg_ready  output  1  loader accepts an entry this cycle.
- cfg_data  input  OUT_BITS  table entry for the current load address.
- cfg_done  output  1  one-cycle pulse after the last entry is written.
- loaded  output  1  high once a complete table has been loaded.
- in_valid  input  1  lookup request valid.
- in_ready  output  1  lookup accepted this cycle.
- in_data  input  IN_BITS  lookup address (packed neuron inputs, M0 packing).
- out_valid  output  1  out_data is valid.
- out_data  output  OUT_BITS  registered table output (M1 packing).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, addr=0, loaded=0.
  - cfg_ready=0, cfg_done=0, in_ready=0, out_valid=0, out_data=0.
  - RAM contents are not reset.
- State machine:
  - IDLE: cfg_start → LOAD with addr=0; otherwise stay. Lookups are not served.
  - LOAD:
    - cfg_ready=1.
    - On cfg_valid&&cfg_ready: write cfg_data to RAM[addr], then addr++.
    - On the write at addr=2^IN_BITS-1: addr wraps to 0, cfg_done pulses high next cycle, loaded←1, state→SERVE.
  - SERVE: in_ready=1. cfg_start → LOAD with addr=0 and loaded←0.
- Entry ordering: entry k is the output for in_data==k (natural binary index).
- Lookup:
  - When in_valid&&in_ready, out_data←RAM[in_data] and out_valid←1 on the next edge. Latency is one cycle.
  - When no request is accepted, out_valid←0 and out_data holds its last value.
  - Back-to-back requests produce throughput 1/cycle.
  - There is no output backpressure; downstream must always accept.
- Boundary conditions:
  - cfg_start during LOAD restarts at addr=0. Entries already written stay in RAM but are overwritten as the load proceeds; loaded stays 0.
  - cfg_start in the same cycle as an accepted lookup in SERVE: the lookup completes normally (out_valid next cycle, old table data). in_ready drops from the following cycle.
  - cfg_valid outside LOAD is ignored. cfg_data must not be consumed and the RAM is not written.
  - in_valid outside SERVE is ignored. out_valid stays 0.
  - Reset mid-load: the partial table is discarded logically (loaded=0). A fresh cfg_start is required.
- Width rules: addr is IN_BITS wide, and its wrap is natural overflow. No arithmetic on data paths.
- Implementation: RAM is inferred as distributed (rom_style/ram_style "distributed"), with a synchronous write and an asynchronous read into the out_data register.

Test Plan:
- Reset then lookups: rst=0→1, in_valid=1 with in_data=8'h05 → in_ready=0, out_valid=0, out_data=2'b00, loaded=0.
- Full load, IN_BITS=8:
  - Pulse cfg_start.
  - Stream 256 entries with entry k = k[1:0], cfg_valid held high.
  - Expect cfg_done one cycle after the 256th accept, and loaded=1.
  - Then in_data=8'hC7 → out_data=2'b11, out_valid one cycle later.
- Stalled stream: during load, toggle cfg_valid randomly for 256 accepts of an all-2'b10 table → no extra/missed writes. Lookups of 8'h00, 8'h80 and 8'hFF all return 2'b10.
- Back-to-back lookups: in_data sequence 0,1,2,3 on consecutive cycles with the table from the full-load scenario → out_data 0,1,2,3 on cycles +1..+4 with out_valid continuously high.
- Reload during load:
  - After 100 entries of all-2'b01, pulse cfg_start.
  - Load 256 entries of all-2'b11.
  - Every address returns 2'b11; cfg_done pulses exactly once.
- Async reset mid-load: assert rst low after 50 entries (off-edge) → all outputs 0 immediately; after release, lookups are refused until a new full load completes.
